// File: rtl/fsm_101_pkg.sv
// fsm_101_pkg: shared types and constants for the "101" sequence detector family.
//   state_e     - sequence generator FSM states
//   PAT_101     - the detected bit pattern, oldest bit in the MSB
//   DEF_*       - default generator parameters
//   is_pat_101  - true when two history bits plus the new bit form PAT_101
package fsm_101_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CNT_W = 5;
    localparam int unsigned DEF_GAP   = 2;

    localparam logic [2:0] PAT_101 = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    // hist[1] is the older of the two previous bits.
    function automatic logic is_pat_101(input logic [1:0] hist, input logic new_bit);
        return {hist, new_bit} == PAT_101;
    endfunction

endpackage

// File: rtl/fsm_101_match_counter.sv
// fsm_101_match_counter: counts overlapping "101" occurrences in a serial bit stream.
// Behaves as the reference twin of the Mealy detector: one increment per detector pulse.
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   clear      - synchronous clear of history and count (start of a new word)
//   in_bit     - serial bit
//   bit_valid  - in_bit carries a payload bit this cycle
//   match_cnt  - registered count, updated the cycle after the completing bit
module fsm_101_match_counter
    import fsm_101_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_bit,
    input  logic             bit_valid,
    output logic [CNT_W-1:0] match_cnt
);

    logic [1:0]       hist_q, hist_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A cleared history of 2'b00 can never look like the leading "10", so the first two
    // bits of a word cannot produce a false match.
    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (clear) begin
            hist_d = 2'b00;
            cnt_d  = '0;
        end else if (bit_valid) begin
            hist_d = {hist_q[0], in_bit};
            if (is_pat_101(hist_q, in_bit)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= 2'b00;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;

endmodule

// File: rtl/fsm_101_seq_gen.sv
// fsm_101_seq_gen: serial pattern transmitter for the fsm_101 detector.
// Captures a word and a bit length, shifts the bits out MSB-first one per clock, then
// inserts GAP idle cycles. Counts overlapping "101" occurrences in the emitted stream.
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   start      - send request, sampled only while idle
//   data       - word; data[len-1] .. data[0] are sent
//   len        - bit count; 0 ignores the request, values above WIDTH clamp to WIDTH
//   out        - serial bit (0 when out_valid is low)
//   out_valid  - out carries a payload bit
//   busy       - high from the first bit through the last gap cycle
//   done       - one-cycle pulse in the cycle after the last bit
//   match_cnt  - "101" count for the current or most recent word
module fsm_101_seq_gen
    import fsm_101_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [CNT_W-1:0] len,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] len_clamped;
    logic [WIDTH-1:0] data_aligned;
    logic             accept;

    assign len_clamped  = (len > WIDTH_C) ? WIDTH_C : len;
    // Left-align the payload so the next bit to send is always shreg[WIDTH-1].
    assign data_aligned = data << (WIDTH_C - len_clamped);
    assign accept       = (state_q == StIdle) && start && (len != '0);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // First bit goes out in the cycle right after the accept edge.
                    state_d     = StShift;
                    out_d       = data_aligned[WIDTH-1];
                    shreg_d     = data_aligned << 1;
                    idx_d       = len_clamped - CNT_W'(1);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            StShift: begin
                busy_d = 1'b1;
                if (idx_q == '0) begin
                    state_d = StGap;
                    done_d  = 1'b1;
                    gap_d   = GAP_W'(GAP - 1);
                end else begin
                    out_d       = shreg_q[WIDTH-1];
                    shreg_d     = shreg_q << 1;
                    idx_d       = idx_q - CNT_W'(1);
                    out_valid_d = 1'b1;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d  = gap_q - GAP_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Watches the registered serial output, so counts land one cycle after each bit.
    fsm_101_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .in_bit    (out_q),
        .bit_valid (out_valid_q),
        .match_cnt (match_cnt)
    );

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
